// File: rtl/alu1_scoreboard_fifo_if.sv
// Issue/response tap bundle for alu1_scoreboard_fifo: the issue side is tapped at
// the ALU1 DUT input, the response side at the DUT output.
interface alu1_scoreboard_fifo_if #(
  parameter int WIDTH = 64
);
  logic             issue_valid;
  logic [3:0]       issue_op;
  logic [WIDTH-1:0] issue_in1;
  logic [WIDTH-1:0] issue_in2;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;

  modport master (
    output issue_valid, issue_op, issue_in1, issue_in2,
    output resp_valid, resp_data
  );

  modport slave (
    input issue_valid, issue_op, issue_in1, issue_in2,
    input resp_valid, resp_data
  );
endinterface

// File: rtl/alu1_scoreboard_fifo.sv
// In-order ALU1 result checker: expected results are queued at issue and compared at response.
// Optional first-mismatch capture is enabled by defining ALU1_SB_CAPTURE_EN.
module alu1_scoreboard_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  alu1_scoreboard_fifo_if.slave    bus,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         pass_count,
  output logic [CNT_W-1:0]         fail_count,
  output logic                     mismatch,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     bad_op,
  output logic [3:0]               err_op,
  output logic [WIDTH-1:0]         err_expected,
  output logic [WIDTH-1:0]         err_actual
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int PEND_W = PTR_W + 1;

  localparam logic [3:0] OP_TRANSFER   = 4'd0;
  localparam logic [3:0] OP_INC        = 4'd1;
  localparam logic [3:0] OP_ADD        = 4'd2;
  localparam logic [3:0] OP_ADD_PLUS1  = 4'd3;
  localparam logic [3:0] OP_SUB_MINUS1 = 4'd4;
  localparam logic [3:0] OP_SUB        = 4'd5;
  localparam logic [3:0] OP_DEC        = 4'd6;
  localparam logic [3:0] OP_TRANSFER2  = 4'd7;
  localparam logic [3:0] OP_AND        = 4'd8;
  localparam logic [3:0] OP_OR         = 4'd9;
  localparam logic [3:0] OP_XOR        = 4'd10;
  localparam logic [3:0] OP_NOT        = 4'd11;

`ifdef ALU1_SB_CAPTURE_EN
  localparam int ENTRY_W = WIDTH + 4;
`else
  localparam int ENTRY_W = WIDTH;
`endif

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [WIDTH-1:0]   expected;
  logic [ENTRY_W-1:0] entry_in;
  logic [ENTRY_W-1:0] head;
  logic [WIDTH-1:0]   head_exp;
  logic               op_legal;
  logic               non_empty;
  logic               push;
  logic               pop;
  logic               match;

  always_comb begin
    expected = bus.issue_in1;
    case (bus.issue_op)
      OP_TRANSFER,
      OP_TRANSFER2:  expected = bus.issue_in1;
      OP_INC:        expected = bus.issue_in1 + WIDTH'(1);
      OP_ADD:        expected = bus.issue_in1 + bus.issue_in2;
      OP_ADD_PLUS1:  expected = bus.issue_in1 + bus.issue_in2 + WIDTH'(1);
      OP_SUB_MINUS1: expected = bus.issue_in1 - bus.issue_in2 - WIDTH'(1);
      OP_SUB:        expected = bus.issue_in1 - bus.issue_in2;
      OP_DEC:        expected = bus.issue_in1 - WIDTH'(1);
      OP_AND:        expected = bus.issue_in1 & bus.issue_in2;
      OP_OR:         expected = bus.issue_in1 | bus.issue_in2;
      OP_XOR:        expected = bus.issue_in1 ^ bus.issue_in2;
      OP_NOT:        expected = ~bus.issue_in1;
      default:       expected = bus.issue_in1;
    endcase
  end

`ifdef ALU1_SB_CAPTURE_EN
  assign entry_in = {bus.issue_op, expected};
`else
  assign entry_in = expected;
`endif

  assign op_legal  = (bus.issue_op < 4'd12);
  assign full      = (pending == PEND_W'(DEPTH));
  assign empty     = (pending == '0);
  assign non_empty = !empty;
  assign head      = mem[rd_ptr];
  assign head_exp  = head[WIDTH-1:0];
  assign match     = (head_exp == bus.resp_data);

  // No bypass: a response on an empty FIFO never sees the same-cycle push.
  assign pop  = bus.resp_valid && non_empty;
  assign push = bus.issue_valid && op_legal && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pending    <= '0;
      pass_count <= '0;
      fail_count <= '0;
      mismatch   <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      bad_op     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   pending <= pending + PEND_W'(1);
        2'b01:   pending <= pending - PEND_W'(1);
        default: pending <= pending;
      endcase
      mismatch <= pop && !match;
      if (pop && match && (pass_count != '1))  pass_count <= pass_count + CNT_W'(1);
      if (pop && !match && (fail_count != '1)) fail_count <= fail_count + CNT_W'(1);
      if (bus.issue_valid && !op_legal)                  bad_op    <= 1'b1;
      if (bus.issue_valid && op_legal && full && !pop)   overflow  <= 1'b1;
      if (bus.resp_valid && !non_empty)                  underflow <= 1'b1;
    end
  end

`ifdef ALU1_SB_CAPTURE_EN
  logic captured;

  always_ff @(posedge clk) begin
    if (rst) begin
      captured     <= 1'b0;
      err_op       <= '0;
      err_expected <= '0;
      err_actual   <= '0;
    end else if (pop && !match && !captured) begin
      captured     <= 1'b1;
      err_op       <= head[ENTRY_W-1:WIDTH];
      err_expected <= head_exp;
      err_actual   <= bus.resp_data;
    end
  end
`else
  assign err_op       = '0;
  assign err_expected = '0;
  assign err_actual   = '0;
`endif

endmodule

// File: tb/tb_alu1_scoreboard_fifo.sv
// Directed bench for alu1_scoreboard_fifo with WIDTH=8, DEPTH=4, CNT_W=4 (saturation at 15).
module tb_alu1_scoreboard_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu1_scoreboard_fifo_if #(.WIDTH(WIDTH)) bus ();

  logic [2:0]       pending;
  logic             full, empty, mismatch, overflow, underflow, bad_op;
  logic [CNT_W-1:0] pass_count, fail_count;
  logic [3:0]       err_op;
  logic [WIDTH-1:0] err_expected, err_actual;

  alu1_scoreboard_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pending(pending), .full(full), .empty(empty),
    .pass_count(pass_count), .fail_count(fail_count), .mismatch(mismatch),
    .overflow(overflow), .underflow(underflow), .bad_op(bad_op),
    .err_op(err_op), .err_expected(err_expected), .err_actual(err_actual)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] exp_res;
    logic [7:0] resp;
  } vec_t;

  vec_t tbl [13];
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] q [$];
  int exp_pass, exp_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid = 1'b0;
    bus.issue_op    = 4'd0;
    bus.issue_in1   = 8'h00;
    bus.issue_in2   = 8'h00;
    bus.resp_valid  = 1'b0;
    bus.resp_data   = 8'h00;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.issue_valid = 1'b1;
    bus.issue_op    = op;
    bus.issue_in1   = a;
    bus.issue_in2   = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pending"},   64'(pending), 64'd0);
    chk({tag, "_empty"},     64'(empty), 64'd1);
    chk({tag, "_full"},      64'(full), 64'd0);
    chk({tag, "_pass"},      64'(pass_count), 64'd0);
    chk({tag, "_fail"},      64'(fail_count), 64'd0);
    chk({tag, "_mismatch"},  64'(mismatch), 64'd0);
    chk({tag, "_overflow"},  64'(overflow), 64'd0);
    chk({tag, "_underflow"}, 64'(underflow), 64'd0);
    chk({tag, "_bad_op"},    64'(bad_op), 64'd0);
    chk({tag, "_err_op"},    64'(err_op), 64'd0);
    chk({tag, "_err_exp"},   64'(err_expected), 64'd0);
    chk({tag, "_err_act"},   64'(err_actual), 64'd0);
  endtask

  initial begin
    tbl[0]  = '{4'd2,  8'hFF, 8'h01, 8'h00, 8'h00};
    tbl[1]  = '{4'd4,  8'h00, 8'h00, 8'hFF, 8'hFE};
    tbl[2]  = '{4'd0,  8'h5A, 8'h33, 8'h5A, 8'h5A};
    tbl[3]  = '{4'd1,  8'hFF, 8'h00, 8'h00, 8'h00};
    tbl[4]  = '{4'd3,  8'h10, 8'h20, 8'h31, 8'h31};
    tbl[5]  = '{4'd5,  8'h10, 8'h20, 8'hF0, 8'hF0};
    tbl[6]  = '{4'd6,  8'h00, 8'h77, 8'hFF, 8'hFF};
    tbl[7]  = '{4'd7,  8'hC3, 8'h11, 8'hC3, 8'hC3};
    tbl[8]  = '{4'd8,  8'hF0, 8'h3C, 8'h30, 8'h30};
    tbl[9]  = '{4'd9,  8'hF0, 8'h3C, 8'hFC, 8'hFC};
    tbl[10] = '{4'd10, 8'hF0, 8'h3C, 8'hCC, 8'hCC};
    tbl[11] = '{4'd11, 8'h0F, 8'h99, 8'hF0, 8'hF0};
    tbl[12] = '{4'd2,  8'h7F, 8'h01, 8'h80, 8'h81};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_reset("reset");

    // Latency-1 vectors over every legal opcode
    exp_pass = 0;
    exp_fail = 0;
    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].op, tbl[i].in1, tbl[i].in2);
      tick();
      idle_inputs();
      bus.resp_valid = 1'b1;
      bus.resp_data  = tbl[i].resp;
      tick();
      idle_inputs();
      if (tbl[i].resp == tbl[i].exp_res) exp_pass++;
      else exp_fail++;
      chk($sformatf("vec%0d_mismatch", i), 64'(mismatch), 64'(tbl[i].resp != tbl[i].exp_res));
      chk($sformatf("vec%0d_pass", i), 64'(pass_count), 64'(exp_pass));
      chk($sformatf("vec%0d_fail", i), 64'(fail_count), 64'(exp_fail));
      chk($sformatf("vec%0d_empty", i), 64'(empty), 64'd1);
    end
    tick();
    chk("vec_mismatch_drop", 64'(mismatch), 64'd0);
`ifdef ALU1_SB_CAPTURE_EN
    chk("cap_err_op",  64'(err_op), 64'd4);
    chk("cap_err_exp", 64'(err_expected), 64'hFF);
    chk("cap_err_act", 64'(err_actual), 64'hFE);
`else
    chk("cap_err_op",  64'(err_op), 64'd0);
    chk("cap_err_exp", 64'(err_expected), 64'd0);
    chk("cap_err_act", 64'(err_actual), 64'd0);
`endif

    // Overflow: five issues into a four-deep FIFO
    do_reset();
    for (int i = 0; i < 5; i++) begin
      issue(4'd1, 8'(i), 8'h00);
      tick();
    end
    idle_inputs();
    chk("ovf_pending",  64'(pending), 64'd4);
    chk("ovf_full",     64'(full), 64'd1);
    chk("ovf_overflow", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) begin
      bus.resp_valid = 1'b1;
      bus.resp_data  = 8'(i + 1);
      tick();
    end
    idle_inputs();
    chk("ovf_drain_pass",  64'(pass_count), 64'd4);
    chk("ovf_drain_empty", 64'(empty), 64'd1);
    chk("ovf_drain_fail",  64'(fail_count), 64'd0);
    chk("ovf_underflow",   64'(underflow), 64'd0);

    // Full FIFO with simultaneous issue and response across pointer wrap
    do_reset();
    q.delete();
    for (int i = 0; i < 4; i++) begin
      issue(4'd1, 8'(10 + i), 8'h00);
      q.push_back(8'(11 + i));
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      issue(4'd1, 8'(20 + k), 8'h00);
      bus.resp_valid = 1'b1;
      bus.resp_data  = q.pop_front();
      q.push_back(8'(21 + k));
      tick();
      chk($sformatf("wrap%0d_pending", k), 64'(pending), 64'd4);
      chk($sformatf("wrap%0d_mismatch", k), 64'(mismatch), 64'd0);
    end
    idle_inputs();
    chk("wrap_overflow", 64'(overflow), 64'd0);
    chk("wrap_pass",     64'(pass_count), 64'd10);
    for (int i = 0; i < 4; i++) begin
      bus.resp_valid = 1'b1;
      bus.resp_data  = q.pop_front();
      tick();
    end
    idle_inputs();
    chk("wrap_drain_pass", 64'(pass_count), 64'd14);
    for (int i = 0; i < 2; i++) begin
      issue(4'd1, 8'h50, 8'h00);
      tick();
      idle_inputs();
      bus.resp_valid = 1'b1;
      bus.resp_data  = 8'h51;
      tick();
      idle_inputs();
      chk($sformatf("sat%0d_pass", i), 64'(pass_count), 64'd15);
    end

    // Response on empty FIFO with a same-cycle issue: no bypass
    do_reset();
    issue(4'd1, 8'h41, 8'h00);
    bus.resp_valid = 1'b1;
    bus.resp_data  = 8'h42;
    tick();
    idle_inputs();
    chk("udf_underflow", 64'(underflow), 64'd1);
    chk("udf_pending",   64'(pending), 64'd1);
    chk("udf_pass",      64'(pass_count), 64'd0);
    chk("udf_fail",      64'(fail_count), 64'd0);
    bus.resp_valid = 1'b1;
    bus.resp_data  = 8'h42;
    tick();
    idle_inputs();
    chk("udf_late_pass", 64'(pass_count), 64'd1);

    // Illegal opcode
    issue(4'd13, 8'h12, 8'h34);
    tick();
    idle_inputs();
    chk("bad_op_flag",    64'(bad_op), 64'd1);
    chk("bad_op_pending", 64'(pending), 64'd0);

    // Back-to-back failures give a continuous mismatch
    issue(4'd10, 8'hAA, 8'h55);
    tick();
    issue(4'd10, 8'hAA, 8'h55);
    tick();
    idle_inputs();
    bus.resp_valid = 1'b1;
    bus.resp_data  = 8'h00;
    tick();
    chk("b2b_mismatch0", 64'(mismatch), 64'd1);
    chk("b2b_fail0",     64'(fail_count), 64'd1);
    tick();
    idle_inputs();
    chk("b2b_mismatch1", 64'(mismatch), 64'd1);
    chk("b2b_fail1",     64'(fail_count), 64'd2);
    tick();
    chk("b2b_mismatch2", 64'(mismatch), 64'd0);

    // Reset mid-traffic with active inputs during the reset cycle
    for (int i = 0; i < 3; i++) begin
      issue(4'd0, 8'(i), 8'h00);
      tick();
    end
    idle_inputs();
    chk("mid_pending", 64'(pending), 64'd3);
    rst = 1'b1;
    issue(4'd1, 8'h01, 8'h00);
    bus.resp_valid = 1'b1;
    bus.resp_data  = 8'h77;
    tick();
    rst = 1'b0;
    idle_inputs();
    check_reset("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu1_scoreboard_fifo.md
# alu1_scoreboard_fifo

Synthesizable, parametrised in-order checker for ALU1-style datapaths with arbitrary latency. Each issued operation has its expected result computed at issue time and queued in a DEPTH-entry FIFO. Each returned DUT result is compared against the FIFO head, and pass/fail statistics plus error flags are kept. It sits beside the DUT in the ALU1 bench (and in emulation builds): issue side tapped at DUT input, response side at DUT output.

## Interface
- WIDTH, 64: operand/result width in bits (>=1).
- DEPTH, 8: max outstanding operations; power of two, >=2.
- CNT_W, 32: width of pass/fail counters.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  operation presented to DUT this cycle.
- issue_op  in  4  opcode: 0 TRANSFER, 1 INC, 2 ADD, 3 ADD_PLUS1, 4 SUB_MINUS1, 5 SUB, 6 DEC, 7 TRANSFER2, 8 AND, 9 OR, 10 XOR, 11 NOT; 12-15 illegal.
- issue_in1  in  WIDTH  operand 1.
- issue_in2  in  WIDTH  operand 2.
- resp_valid  in  1  DUT result valid this cycle.
- resp_data  in  WIDTH  DUT result.
- pending  out  $clog2(DEPTH)+1  entries in FIFO.
- full / empty  out  1  pending==DEPTH / pending==0.
- pass_count / fail_count  out  CNT_W  saturating compare counters.
- mismatch  out  1  one-cycle pulse per failed compare.
- overflow / underflow / bad_op  out  1  sticky error flags.
- err_op  out  4, err_expected / err_actual  out  WIDTH  first-mismatch capture (macro only).

## Operation
- Expected value at issue, all arithmetic modulo 2^WIDTH: TRANSFER/TRANSFER2 = in1; INC = in1+1; ADD = in1+in2; ADD_PLUS1 = in1+in2+1; SUB_MINUS1 = in1-in2-1; SUB = in1-in2; DEC = in1-1; AND/OR/XOR bitwise; NOT = ~in1.
- Push: issue_valid with legal op and (not full, or resp_valid same cycle with FIFO non-empty) -> {op, expected} written at tail.
- Issue with illegal op: not stored; bad_op set.
- Issue while full without simultaneous pop: dropped; overflow set.
- Pop/compare: resp_valid and FIFO non-empty -> head compared with resp_data. Equal: pass_count+1. Unequal: fail_count+1, mismatch pulse.
- resp_valid while empty: no compare, no counter change; underflow set. This holds even with a same-cycle push; the pushed entry is retained. There is no bypass.
- Simultaneous push and pop: pending unchanged; pointers both advance and wrap modulo DEPTH.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Sticky flags clear only on rst.
- Reset: pointers 0, pending 0, empty 1, full 0, counters 0, mismatch 0, overflow/underflow/bad_op 0, err_* 0.
- rst asserted mid-traffic: all outstanding entries discarded. Inputs in the rst cycle are ignored.

## Timing
- Push visible in pending/empty/full on the cycle after issue_valid.
- Compare registered: counters and mismatch update on the cycle after resp_valid. mismatch is high for exactly that one cycle per failure; back-to-back failures give a continuous high.
- Flags set on the cycle after the offending input.
- Earliest legal response is the cycle after issue, because there is no same-cycle bypass. DUT latency 1..any, in-order.

## Configuration
- ALU1_SB_CAPTURE_EN defined:
  - On the first failed compare since reset, err_op, err_expected and err_actual latch the head op, expected value and resp_data.
  - The latched values are held until rst; later failures do not overwrite them.
- ALU1_SB_CAPTURE_EN undefined:
  - The capture ports remain present but are tied to 0.
  - The FIFO stores only the expected value, with no op field.

## Test plan
- WIDTH=8, latency 1: ADD 0xFF+0x01, then resp 0x00 -> pass_count=1, fail_count=0, mismatch never high.
- WIDTH=8: SUB_MINUS1 0x00,0x00 with resp 0xFE -> fail_count=1, mismatch one cycle. With capture: err_op=4, err_expected=0xFF, err_actual=0xFE.
- DEPTH=4: 5 issues without responses -> pending=4, full=1, overflow=1. Then 4 correct responses -> pass_count=4, empty=1.
- DEPTH=4 full: issue + resp same cycle -> pending stays 4, no overflow. Run 10 such cycles to cover pointer wrap; all pass.
- Empty FIFO: resp_valid with a simultaneous INC issue -> underflow=1, pending=1, counters 0. Then resp with in1+1 -> pass_count=1.
- Issue op 13 -> bad_op=1, pending unchanged. Assert rst with 3 entries pending -> all outputs return to reset values on the next cycle.
